// File: rtl/seven_segment_capture.sv
// seven_segment_capture: recovers the digits shown on a multiplexed 4-digit active-low
// seven-segment display. Optional change counter: SEVEN_SEGMENT_CAPTURE_CHANGE_COUNT_EN.
`default_nettype none

module seven_segment_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        pattern_err,
    output logic        anode_err,
    output logic        capture_stb,
    output logic [15:0] change_count
);

    localparam logic [15:0] STABLE_MAX  = 16'(STABLE_CYCLES);
    localparam logic [19:0] TIMEOUT_MAX = 20'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t      state;
    logic [6:0]  seg_s1, seg_s2;
    logic [3:0]  an_s1, an_s2;
    logic [10:0] prev;
    logic [15:0] stable_cnt;
    logic [19:0] tcnt  [4];
    logic [19:0] tnext [4];

    logic       input_change, accept, multi_anode, blank, dec_ok, capture;
    logic [3:0] an_low, dec_val;
    logic [1:0] pos;

    assign input_change = {an_s2, seg_s2} != prev;
    assign accept       = (state == SETTLE) && !input_change && (stable_cnt == STABLE_MAX);
    assign an_low       = ~an_s2;
    assign multi_anode  = (an_low & (an_low - 4'd1)) != 4'd0;
    assign blank        = (seg_s2 == 7'h7F);
    assign capture      = accept && !multi_anode && dec_ok;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (seg_s2)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b0111111: dec_val = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // Only meaningful when exactly one anode is low; multi-anode acceptances never use pos.
    always_comb begin
        case (an_s2)
            4'b1110: pos = 2'd0;
            4'b1101: pos = 2'd1;
            4'b1011: pos = 2'd2;
            default: pos = 2'd3;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            tnext[k] = (tcnt[k] == 20'hFFFFF) ? tcnt[k] : tcnt[k] + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1      <= 7'h7F;
            seg_s2      <= 7'h7F;
            an_s1       <= 4'hF;
            an_s2       <= 4'hF;
            prev        <= 11'h7FF;
            stable_cnt  <= 16'd0;
            state       <= IDLE;
            digits      <= 16'h0000;
            digit_valid <= 4'b0000;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            capture_stb <= 1'b0;
            for (int k = 0; k < 4; k++) tcnt[k] <= 20'd0;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            an_s1  <= an_in;
            an_s2  <= an_s1;
            prev   <= {an_s2, seg_s2};

            if (input_change)
                stable_cnt <= 16'd0;
            else if (stable_cnt != STABLE_MAX)
                stable_cnt <= stable_cnt + 16'd1;

            if (input_change)
                state <= (an_s2 == 4'hF) ? IDLE : SETTLE;
            else if (accept)
                state <= HELD;

            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
            capture_stb <= 1'b0;

            for (int k = 0; k < 4; k++) begin
                tcnt[k] <= tnext[k];
                if (tnext[k] >= TIMEOUT_MAX) digit_valid[k] <= 1'b0;
            end

            // Assignments below come later so a same-cycle capture beats the timeout.
            if (accept) begin
                if (multi_anode) begin
                    anode_err <= 1'b1;
                end else if (dec_ok) begin
                    digits[{pos, 2'b00} +: 4] <= dec_val;
                    digit_valid[pos]          <= 1'b1;
                    tcnt[pos]                 <= 20'd0;
                    capture_stb               <= 1'b1;
                end else if (!blank) begin
                    pattern_err      <= 1'b1;
                    digit_valid[pos] <= 1'b0;
                end
            end
        end
    end

`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_COUNT_EN
    logic [3:0] old_nib;
    assign old_nib = digits[{pos, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst)
            change_count <= 16'd0;
        else if (capture && ((dec_val != old_nib) || !digit_valid[pos]))
            change_count <= change_count + 16'd1;
    end
`else
    assign change_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: decode table, timing/timeout sequences and randomized
// traffic checked every cycle against a pin-history reference model.
`default_nettype none

module tb_seven_segment_capture;

    localparam int S    = 16;
    localparam int T    = 1000;
    localparam int MAXC = 30000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        pattern_err, anode_err, capture_stb;
    logic [15:0] change_count;

    seven_segment_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .digits(digits), .digit_valid(digit_valid), .pattern_err(pattern_err),
        .anode_err(anode_err), .capture_stb(capture_stb), .change_count(change_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int t = 100;
    int n_stb = 0, n_perr = 0, n_aerr = 0;

    // Reference model: pin history per edge plus per-position digit state.
    logic [10:0] hist [0:MAXC];
    logic [3:0]  m_dig [4];
    bit          m_flag [4];
    int          m_last [4];
    logic [15:0] m_cc;
    bit          m_stb, m_perr, m_aerr;
    logic [6:0]  pats [11];

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0111111: return {1'b1, 4'hF};
            default:    return 5'd0;
        endcase
    endfunction

    function automatic bit m_valid(input int k, input int at);
        return m_flag[k] && ((at - m_last[k]) < T);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [10:0] v);
        bit          vb [4];
        bit          run_ok;
        logic [10:0] cand;
        logic [4:0]  dec;
        int          lows, k;
        hist[t] = r ? 11'h7FF : v;
        m_stb = 0; m_perr = 0; m_aerr = 0;
        if (r) begin
            for (int i = 0; i < 4; i++) begin m_flag[i] = 0; m_dig[i] = 4'h0; end
            m_cc = 16'h0;
            return;
        end
        for (int i = 0; i < 4; i++) vb[i] = m_valid(i, t - 1);
        // A sample is taken when the synchronized value has been constant for S+2 edges.
        cand = hist[t-2];
        run_ok = (hist[t-4-S] != cand) && (cand[10:7] != 4'hF);
        for (int i = t - 3 - S; i <= t - 2; i++) if (hist[i] != cand) run_ok = 0;
        if (!run_ok) return;
        lows = 0; k = 0;
        for (int i = 0; i < 4; i++) if (!cand[7+i]) begin lows++; k = i; end
        dec = ref_decode(cand[6:0]);
        if (lows > 1) begin
            m_aerr = 1;
        end else if (dec[4]) begin
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_COUNT_EN
            if (m_dig[k] != dec[3:0] || !vb[k]) m_cc = m_cc + 16'd1;
`endif
            m_dig[k] = dec[3:0]; m_flag[k] = 1; m_last[k] = t; m_stb = 1;
        end else if (cand[6:0] != 7'h7F) begin
            m_perr = 1; m_flag[k] = 0;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
        logic [3:0] mv;
        rst = r; an_in = a; seg_in = s;
        @(posedge clk);
        t++;
        if (t >= MAXC) begin
            $display("FAIL cycle_budget: t=%0d exceeds %0d", t, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        model_edge(r, {a, s});
        #1;
        for (int i = 0; i < 4; i++) mv[i] = m_valid(i, t);
        check("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        check("digit_valid", 32'(digit_valid), 32'(mv));
        check("capture_stb", 32'(capture_stb), 32'(m_stb));
        check("pattern_err", 32'(pattern_err), 32'(m_perr));
        check("anode_err", 32'(anode_err), 32'(m_aerr));
        check("change_count", 32'(change_count), 32'(m_cc));
        n_stb  += int'(capture_stb);
        n_perr += int'(pattern_err);
        n_aerr += int'(anode_err);
    endtask

    task automatic hold(input int n, input logic [3:0] a, input logic [6:0] s);
        for (int i = 0; i < n; i++) step(1'b0, a, s);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'hF, 7'h7F);
    endtask

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         pos;
        logic [3:0] nib;
        bit         v, stb, perr, aerr;
    } vec_t;

    vec_t tab [16];

    initial begin
        int first, c0, found, exp_cc;
        for (int i = 0; i <= 100; i++) hist[i] = 11'h7FF;
        pats = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111};
        tab[0]  = '{4'b1110, 7'b1000000, 0, 4'h0, 1, 1, 0, 0};
        tab[1]  = '{4'b1110, 7'b1111001, 0, 4'h1, 1, 1, 0, 0};
        tab[2]  = '{4'b1110, 7'b0100100, 0, 4'h2, 1, 1, 0, 0};
        tab[3]  = '{4'b1110, 7'b0110000, 0, 4'h3, 1, 1, 0, 0};
        tab[4]  = '{4'b1110, 7'b0011001, 0, 4'h4, 1, 1, 0, 0};
        tab[5]  = '{4'b1110, 7'b0010010, 0, 4'h5, 1, 1, 0, 0};
        tab[6]  = '{4'b1110, 7'b0000010, 0, 4'h6, 1, 1, 0, 0};
        tab[7]  = '{4'b1110, 7'b1111000, 0, 4'h7, 1, 1, 0, 0};
        tab[8]  = '{4'b1110, 7'b0000000, 0, 4'h8, 1, 1, 0, 0};
        tab[9]  = '{4'b1110, 7'b0010000, 0, 4'h9, 1, 1, 0, 0};
        tab[10] = '{4'b1110, 7'b0111111, 0, 4'hF, 1, 1, 0, 0};
        tab[11] = '{4'b1110, 7'b1111111, 0, 4'hF, 1, 0, 0, 0};
        tab[12] = '{4'b1110, 7'b1010101, 0, 4'hF, 0, 0, 1, 0};
        tab[13] = '{4'b1101, 7'b0000000, 1, 4'h8, 1, 1, 0, 0};
        tab[14] = '{4'b0110, 7'b1111001, 1, 4'h8, 1, 0, 0, 1};
        tab[15] = '{4'b1011, 7'b0110000, 2, 4'h3, 1, 1, 0, 0};

        rst = 1'b1; an_in = 4'hF; seg_in = 7'h7F;
        do_reset(3);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_count", 32'(change_count), 32'h0);

        // Single digit: capture strobe lands exactly S+3 edges after the pattern appears.
        first = -1; c0 = n_stb;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b0111, 7'b0010010);
            if (capture_stb && first < 0) first = i;
        end
        check("stb_latency", 32'(first), 32'(S + 3));
        check("stb_count", 32'(n_stb - c0), 32'd1);
        check("digit5", 32'(digits[15:12]), 32'h5);
        check("valid5", 32'(digit_valid), 32'b1000);

        // Decode table.
        for (int e = 0; e < 16; e++) begin
            int s0, p0, a0;
            s0 = n_stb; p0 = n_perr; a0 = n_aerr;
            hold(S + 10, tab[e].an, tab[e].seg);
            hold(4, 4'hF, 7'h7F);
            check($sformatf("tab%0d_stb", e), 32'(n_stb - s0), 32'(tab[e].stb));
            check($sformatf("tab%0d_perr", e), 32'(n_perr - p0), 32'(tab[e].perr));
            check($sformatf("tab%0d_aerr", e), 32'(n_aerr - a0), 32'(tab[e].aerr));
            check($sformatf("tab%0d_nib", e), 32'(digits[4*tab[e].pos +: 4]), 32'(tab[e].nib));
            check($sformatf("tab%0d_valid", e), 32'(digit_valid[tab[e].pos]), 32'(tab[e].v));
        end

        // Short glitch must not capture.
        c0 = n_stb;
        hold(10, 4'b0111, 7'b1111001);
        hold(20, 4'hF, 7'h7F);
        check("glitch_no_capture", 32'(n_stb - c0), 32'd0);

        // Alternating positions.
        do_reset(2);
        c0 = n_stb; first = n_perr + n_aerr;
        for (int i = 0; i < 4; i++) begin
            hold(300, 4'b0111, 7'b0100100);
            hold(300, 4'b1110, 7'b1111000);
        end
        check("alt_digits", 32'(digits), 32'h2007);
        check("alt_valid", 32'(digit_valid), 32'b1001);
        check("alt_errors", 32'(n_perr + n_aerr - first), 32'd0);
        check("alt_captures", 32'(n_stb - c0), 32'd8);

        // Timeout: valid clears exactly T cycles after the capture.
        do_reset(2);
        c0 = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b1110, 7'b0110000);
            if (capture_stb) c0 = t;
        end
        found = -1;
        for (int i = 0; i < T + 50 && found < 0; i++) begin
            step(1'b0, 4'hF, 7'h7F);
            if (!digit_valid[0]) found = t;
        end
        check("timeout_capture_seen", 32'(c0 >= 0), 32'd1);
        check("timeout_delay", 32'(found - c0), 32'(T));

        // Change counting: 3, 3, 4.
        do_reset(2);
        hold(30, 4'b1110, 7'b0110000); hold(3, 4'hF, 7'h7F);
        hold(30, 4'b1110, 7'b0110000); hold(3, 4'hF, 7'h7F);
        hold(30, 4'b1110, 7'b0011001); hold(3, 4'hF, 7'h7F);
`ifdef SEVEN_SEGMENT_CAPTURE_CHANGE_COUNT_EN
        exp_cc = 2;
`else
        exp_cc = 0;
`endif
        check("change_count_334", 32'(change_count), 32'(exp_cc));

        // Reset mid-settle aborts the pending acceptance.
        hold(10, 4'b1101, 7'b1111001);
        do_reset(1);
        c0 = n_stb; first = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b1101, 7'b1111001);
            if (capture_stb && first < 0) first = i;
        end
        check("reset_abort_latency", 32'(first), 32'(S + 3));
        check("reset_abort_count", 32'(n_stb - c0), 32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic [3:0] a;
            logic [6:0] s;
            int r1, r2;
            r1 = $urandom_range(0, 9);
            r2 = $urandom_range(0, 9);
            if (r1 == 0)      a = 4'hF;
            else if (r1 == 1) a = 4'($urandom);
            else              a = ~(4'b0001 << $urandom_range(0, 3));
            if (r2 == 0)      s = 7'h7F;
            else if (r2 == 1) s = 7'($urandom);
            else              s = pats[$urandom_range(0, 10)];
            if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 3));
            hold($urandom_range(1, 40), a, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
